// File: rtl/execute_pipe.sv
// Execute stage: single-cycle ALU/branch operations plus an iterative shift-add multiplier
// and restoring divider, all feeding a one-entry valid/ready output slot.
module execute_pipe #(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            flush,
   input  logic [4:0]      op,
   input  logic            use_imm,
   input  logic [XLEN-1:0] rs1_value,
   input  logic [XLEN-1:0] rs2_value,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] PC,
   input  logic [4:0]      in_RegDest,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic [4:0]      out_RegDest,
   output logic            branch_taken,
   output logic [XLEN-1:0] branch_target
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV
   } state_e;

   localparam logic [4:0]   OP_MUL    = 5'd24;
   localparam logic [SHW:0] LAST_ITER = (SHW+1)'(XLEN-1);

   state_e          state_q, state_d;
   logic [SHW:0]    cnt_q, cnt_d;
   logic            vld_q, vld_d;
   logic [XLEN-1:0] res_q, res_d;
   logic [4:0]      rd_q, rd_d;
   logic            taken_q, taken_d;
   logic [XLEN-1:0] target_q, target_d;

   logic [XLEN-1:0] opa_q, opa_d, opb_q, opb_d, acc_q, acc_d;
   logic [4:0]      lrd_q, lrd_d;
   logic            is_rem_q, is_rem_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

   logic [XLEN-1:0] opb, alu_res, alu_target;
   logic [SHW-1:0]  shamt;
   logic            br_cond, alu_taken;
   logic            slot_free, accept, is_div, div_signed;

   logic [XLEN-1:0] mul_acc_nx, div_quo_nx, div_rem_nx, quo_fin, rem_fin, div_fin;
   logic [XLEN:0]   div_shift, div_diff;
   logic            div_ge;

   assign opb        = use_imm ? imm : rs2_value;
   assign shamt      = opb[SHW-1:0];
   assign slot_free  = !vld_q || out_ready;
   assign in_ready   = !rst && (state_q == S_IDLE) && slot_free && !flush;
   assign accept     = in_valid && in_ready;
   assign is_div     = (op[4:2] == 3'b111);
   assign div_signed = !op[0];

   // Branches always compare the two registers, never the immediate.
   always_comb begin
      br_cond = 1'b0;
      case (op)
         5'd16:   br_cond = (rs1_value == rs2_value);
         5'd17:   br_cond = (rs1_value != rs2_value);
         5'd20:   br_cond = ($signed(rs1_value) <  $signed(rs2_value));
         5'd21:   br_cond = ($signed(rs1_value) >= $signed(rs2_value));
         5'd22:   br_cond = (rs1_value <  rs2_value);
         5'd23:   br_cond = (rs1_value >= rs2_value);
         default: br_cond = 1'b0;
      endcase
   end

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      alu_res    = rs1_value + opb;
      alu_taken  = 1'b0;
      alu_target = '0;
      case (op)
         5'd1:  alu_res = rs1_value - opb;
         5'd2:  alu_res = rs1_value << shamt;
         5'd3:  alu_res = XLEN'($signed(rs1_value) < $signed(opb));
         5'd4:  alu_res = XLEN'(rs1_value < opb);
         5'd5:  alu_res = rs1_value ^ opb;
         5'd6:  alu_res = rs1_value >> shamt;
         5'd7:  alu_res = $unsigned($signed(rs1_value) >>> shamt);
         5'd8:  alu_res = rs1_value | opb;
         5'd9:  alu_res = rs1_value & opb;
         5'd10: alu_res = opb;
         5'd11: alu_res = PC + opb;
         5'd16, 5'd17, 5'd20, 5'd21, 5'd22, 5'd23: begin
            alu_res    = PC + XLEN'(4);
            alu_target = PC + imm;
            alu_taken  = br_cond;
         end
         default: ;
      endcase
   end

   // One multiply or divide step; on the last iteration these feed the slot directly.
   always_comb begin
      mul_acc_nx = acc_q + (opb_q[0] ? opa_q : '0);
      div_shift  = {acc_q, opa_q[XLEN-1]};
      div_diff   = div_shift - {1'b0, opb_q};
      div_ge     = (div_shift >= {1'b0, opb_q});
      div_quo_nx = {opa_q[XLEN-2:0], div_ge};
      div_rem_nx = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      quo_fin    = (opb_q == '0) ? '1 : (neg_quo_q ? -div_quo_nx : div_quo_nx);
      rem_fin    = neg_rem_q ? -div_rem_nx : div_rem_nx;
      div_fin    = is_rem_q ? rem_fin : quo_fin;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      vld_d     = vld_q && !out_ready;
      res_d     = res_q;
      rd_d      = rd_q;
      taken_d   = taken_q;
      target_d  = target_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      acc_d     = acc_q;
      lrd_d     = lrd_q;
      is_rem_d  = is_rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;

      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         vld_d   = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  if (op == OP_MUL) begin
                     state_d = S_MUL;
                     opa_d   = rs1_value;
                     opb_d   = opb;
                     acc_d   = '0;
                     lrd_d   = in_RegDest;
                  end else if (is_div) begin
                     // Divide on magnitudes; signs are restored on the final edge.
                     state_d   = S_DIV;
                     opa_d     = (div_signed && rs1_value[XLEN-1]) ? -rs1_value : rs1_value;
                     opb_d     = (div_signed && opb[XLEN-1]) ? -opb : opb;
                     acc_d     = '0;
                     lrd_d     = in_RegDest;
                     is_rem_d  = op[1];
                     neg_quo_d = div_signed && (rs1_value[XLEN-1] ^ opb[XLEN-1]);
                     neg_rem_d = div_signed && rs1_value[XLEN-1];
                  end else begin
                     vld_d    = 1'b1;
                     res_d    = alu_res;
                     rd_d     = in_RegDest;
                     taken_d  = alu_taken;
                     target_d = alu_target;
                  end
               end
            end
            S_MUL: begin
               if (cnt_q != LAST_ITER) begin
                  acc_d = mul_acc_nx;
                  opa_d = opa_q << 1;
                  opb_d = opb_q >> 1;
                  cnt_d = cnt_q + (SHW+1)'(1);
               end else if (slot_free) begin
                  state_d  = S_IDLE;
                  cnt_d    = '0;
                  vld_d    = 1'b1;
                  res_d    = mul_acc_nx;
                  rd_d     = lrd_q;
                  taken_d  = 1'b0;
                  target_d = '0;
               end
            end
            S_DIV: begin
               if (cnt_q != LAST_ITER) begin
                  acc_d = div_rem_nx;
                  opa_d = div_quo_nx;
                  cnt_d = cnt_q + (SHW+1)'(1);
               end else if (slot_free) begin
                  state_d  = S_IDLE;
                  cnt_d    = '0;
                  vld_d    = 1'b1;
                  res_d    = div_fin;
                  rd_d     = lrd_q;
                  taken_d  = 1'b0;
                  target_d = '0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         vld_q    <= 1'b0;
         res_q    <= '0;
         rd_q     <= '0;
         taken_q  <= 1'b0;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         vld_q    <= vld_d;
         res_q    <= res_d;
         rd_q     <= rd_d;
         taken_q  <= taken_d;
         target_q <= target_d;
      end
   end

   // NOTE: the iteration datapath is reloaded on every accept, so it carries no reset.
   always_ff @(posedge clk) begin
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      lrd_q     <= lrd_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
   end

   assign out_valid     = vld_q;
   assign result        = res_q;
   assign out_RegDest   = rd_q;
   assign branch_taken  = taken_q;
   assign branch_target = target_q;

endmodule

// File: tb/tb_execute_pipe.sv
// Self-checking bench for execute_pipe: directed corner cases plus randomized traffic
// scored against an arithmetic reference model; rerun with XLEN=64 for the wide variant.
module tb_execute_pipe;

   parameter int XLEN = 32;
   localparam int SHW    = $clog2(XLEN);
   localparam int BUDGET = 4*XLEN + 20;
   localparam logic [XLEN-1:0] MIN_V = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ONES  = '1;

   logic            clk, rst, in_valid, in_ready, flush, use_imm;
   logic [4:0]      op, in_RegDest, out_RegDest;
   logic [XLEN-1:0] rs1_value, rs2_value, imm, PC, result, branch_target;
   logic            out_valid, out_ready, branch_taken;

   execute_pipe #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .op(op), .use_imm(use_imm), .rs1_value(rs1_value), .rs2_value(rs2_value),
      .imm(imm), .PC(PC), .in_RegDest(in_RegDest), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .out_RegDest(out_RegDest),
      .branch_taken(branch_taken), .branch_target(branch_target)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [XLEN-1:0] res;
      logic [4:0]      rd;
      logic            taken;
      logic            is_br;
      logic [XLEN-1:0] target;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_xfer   = 0;
   bit   done     = 1'b0;

   logic [4:0] op_tbl [26] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                               5'd10, 5'd11, 5'd16, 5'd17, 5'd20, 5'd21, 5'd22, 5'd23,
                               5'd24, 5'd28, 5'd29, 5'd30, 5'd31, 5'd12, 5'd18, 5'd26};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [4:0] o, input logic [XLEN-1:0] a, r2, i, p,
                                  input logic ui, input logic [4:0] rd);
      exp_t m;
      logic [XLEN-1:0] b;
      logic signed [XLEN-1:0] sa, sb, s2;
      int sh;
      b  = ui ? i : r2;
      sa = a;
      sb = b;
      s2 = r2;
      sh = int'(b[SHW-1:0]);
      m.res    = a + b;
      m.rd     = rd;
      m.taken  = 1'b0;
      m.is_br  = 1'b0;
      m.target = '0;
      case (o)
         5'd1:  m.res = a - b;
         5'd2:  m.res = a << sh;
         5'd3:  m.res = (sa < sb) ? XLEN'(1) : '0;
         5'd4:  m.res = (a < b) ? XLEN'(1) : '0;
         5'd5:  m.res = a ^ b;
         5'd6:  m.res = a >> sh;
         5'd7:  m.res = sa >>> sh;
         5'd8:  m.res = a | b;
         5'd9:  m.res = a & b;
         5'd10: m.res = b;
         5'd11: m.res = p + b;
         5'd16, 5'd17, 5'd20, 5'd21, 5'd22, 5'd23: begin
            m.is_br  = 1'b1;
            m.res    = p + XLEN'(4);
            m.target = p + i;
            case (o)
               5'd16:   m.taken = (a == r2);
               5'd17:   m.taken = (a != r2);
               5'd20:   m.taken = (sa < s2);
               5'd21:   m.taken = (sa >= s2);
               5'd22:   m.taken = (a < r2);
               default: m.taken = (a >= r2);
            endcase
         end
         5'd24: m.res = a * b;
         5'd28: begin
            if (b == '0)                       m.res = ONES;
            else if (a == MIN_V && b == ONES)  m.res = MIN_V;
            else                               m.res = sa / sb;
         end
         5'd29: m.res = (b == '0) ? ONES : a / b;
         5'd30: begin
            if (b == '0)                       m.res = a;
            else if (a == MIN_V && b == ONES)  m.res = '0;
            else                               m.res = sa % sb;
         end
         5'd31: m.res = (b == '0) ? a : a % b;
         default: ;
      endcase
      return m;
   endfunction

   function automatic logic [XLEN-1:0] rnd();
      logic [63:0] w;
      w = {$urandom(), $urandom()};
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return ONES;
         2:       return MIN_V;
         3:       return ~MIN_V;
         4:       return XLEN'($urandom_range(0, 9));
         5:       return ONES - XLEN'($urandom_range(0, 9));
         default: return w[XLEN-1:0];
      endcase
   endfunction

   // Scoreboard: every transfer out of the slot must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         n_xfer++;
         if (sb.size() == 0) begin
            check("unexpected_out", out_valid, 0);
         end else begin
            mon_e = sb.pop_front();
            check("mon_result", result, mon_e.res);
            check("mon_rd", out_RegDest, mon_e.rd);
            check("mon_taken", branch_taken, mon_e.taken);
            if (mon_e.is_br) check("mon_target", branch_target, mon_e.target);
         end
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic issue(input logic [4:0] o, input logic [XLEN-1:0] a, r2, i, p,
                        input logic ui, input logic [4:0] rd, input bit expect_out,
                        output int waits);
      op = o; rs1_value = a; rs2_value = r2; imm = i; PC = p; use_imm = ui;
      in_RegDest = rd;
      in_valid = 1'b1;
      waits = 0;
      @(negedge clk);
      while (!in_ready && waits < BUDGET) begin
         waits++;
         @(negedge clk);
      end
      if (!in_ready) check("accept_timeout", in_ready, 1);
      else if (expect_out) sb.push_back(model(o, a, r2, i, p, ui, rd));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < BUDGET) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic do_op(input string tag, input logic [4:0] o, input logic [XLEN-1:0] a, r2, i, p,
                        input logic ui, input logic [4:0] rd, input int exp_lat,
                        input logic [XLEN-1:0] exp_res, input logic exp_taken,
                        input logic [XLEN-1:0] exp_tgt);
      int w, lat;
      issue(o, a, r2, i, p, ui, rd, 1'b1, w);
      wait_out(lat);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_res"}, result, exp_res);
      check({tag, "_taken"}, branch_taken, exp_taken);
      if (o inside {5'd16, 5'd17, 5'd20, 5'd21, 5'd22, 5'd23}) check({tag, "_tgt"}, branch_target, exp_tgt);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, lat, seen, x0, t;
      logic [4:0] o;
      rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; use_imm = 1'b0;
      op = '0; rs1_value = '0; rs2_value = '0; imm = '0; PC = '0; in_RegDest = '0;

      #2 rst = 1'b1;
      #10;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_rd", out_RegDest, 0);
      check("rst_taken", branch_taken, 0);
      check("rst_target", branch_target, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", in_ready, 1);
      @(posedge clk); #1;

      do_op("add", 5'd0, XLEN'(5), XLEN'(7), '0, '0, 1'b0, 5'd1, 1, XLEN'(12), 1'b0, '0);
      do_op("sub", 5'd1, '0, XLEN'(1), '0, '0, 1'b0, 5'd2, 1, ONES, 1'b0, '0);
      do_op("addi", 5'd0, XLEN'(5), XLEN'(99), XLEN'(3), '0, 1'b1, 5'd3, 1, XLEN'(8), 1'b0, '0);
      do_op("blt", 5'd20, ONES, XLEN'(1), XLEN'('h20), XLEN'('h100), 1'b0, 5'd4, 1,
            XLEN'('h104), 1'b1, XLEN'('h120));
      do_op("bltu", 5'd22, ONES, XLEN'(1), XLEN'('h20), XLEN'('h100), 1'b0, 5'd5, 1,
            XLEN'('h104), 1'b0, XLEN'('h120));
      do_op("div_by0", 5'd28, XLEN'(7), '0, '0, '0, 1'b0, 5'd6, XLEN+1, ONES, 1'b0, '0);
      do_op("rem_by0", 5'd30, XLEN'(7), '0, '0, '0, 1'b0, 5'd7, XLEN+1, XLEN'(7), 1'b0, '0);
      do_op("div_ovf", 5'd28, MIN_V, ONES, '0, '0, 1'b0, 5'd8, XLEN+1, MIN_V, 1'b0, '0);
      do_op("rem_ovf", 5'd30, MIN_V, ONES, '0, '0, 1'b0, 5'd9, XLEN+1, '0, 1'b0, '0);
      do_op("div_neg", 5'd28, -XLEN'(7), XLEN'(2), '0, '0, 1'b0, 5'd10, XLEN+1, -XLEN'(3), 1'b0, '0);
      do_op("rem_neg", 5'd30, -XLEN'(7), XLEN'(2), '0, '0, 1'b0, 5'd11, XLEN+1, ONES, 1'b0, '0);
      do_op("divu_max", 5'd29, ONES, XLEN'(16), '0, '0, 1'b0, 5'd12, XLEN+1, ONES >> 4, 1'b0, '0);
      do_op("mul", 5'd24, XLEN'(6), XLEN'(7), '0, '0, 1'b0, 5'd13, XLEN+1, XLEN'(42), 1'b0, '0);
      do_op("mul_ext", 5'd24, ONES, ONES, '0, '0, 1'b0, 5'd14, XLEN+1, XLEN'(1), 1'b0, '0);

      for (int k = 0; k < 6; k++) begin
         issue(5'd0, XLEN'(k), XLEN'(100), '0, '0, 1'b0, 5'(k), 1'b1, w);
         check("b2b_wait", w, 0);
      end
      repeat (2) begin @(posedge clk); #1; end
      check("b2b_drain", sb.size(), 0);

      out_ready = 1'b0;
      issue(5'd24, XLEN'(9), XLEN'(11), '0, '0, 1'b0, 5'd7, 1'b1, w);
      wait_out(lat);
      check("stall_lat", lat, XLEN+1);
      for (int k = 0; k < 5; k++) begin
         check("stall_valid", out_valid, 1);
         check("stall_res", result, 99);
         check("stall_rd", out_RegDest, 7);
         check("stall_in_ready", in_ready, 0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      x0 = n_xfer;
      @(negedge clk);
      @(posedge clk); #1;
      check("stall_one_xfer", n_xfer - x0, 1);
      check("stall_cleared", out_valid, 0);
      check("stall_ready_after", in_ready, 1);

      issue(5'd29, XLEN'(1000), XLEN'(3), '0, '0, 1'b0, 5'd9, 1'b0, w);
      repeat (10) @(posedge clk);
      #1;
      flush = 1'b1;
      op = 5'd0; rs1_value = XLEN'(20); rs2_value = XLEN'(22); use_imm = 1'b0;
      in_RegDest = 5'd12; in_valid = 1'b1;
      @(negedge clk);
      check("flush_in_ready", in_ready, 0);
      @(posedge clk); #1;
      flush = 1'b0;
      issue(5'd0, XLEN'(20), XLEN'(22), '0, '0, 1'b0, 5'd12, 1'b1, w);
      check("flush_next_wait", w, 0);
      wait_out(lat);
      check("flush_next_lat", lat, 1);
      check("flush_next_res", result, 42);
      seen = 0;
      repeat (XLEN + 5) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      check("flush_no_div_out", seen, 0);
      @(posedge clk); #1;

      issue(5'd24, XLEN'(3), XLEN'(5), '0, '0, 1'b0, 5'd4, 1'b0, w);
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("midrst_in_ready", in_ready, 0);
      check("midrst_valid", out_valid, 0);
      check("midrst_result", result, 0);
      @(posedge clk); #2 rst = 1'b0;
      seen = 0;
      repeat (XLEN + 5) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      check("midrst_no_out", seen, 0);
      @(posedge clk); #1;
      do_op("add_after_rst", 5'd0, XLEN'(1), XLEN'(2), '0, '0, 1'b0, 5'd3, 1, XLEN'(3), 1'b0, '0);

      fork
         begin
            for (int n = 0; n < 300; n++) begin
               o = op_tbl[$urandom_range(0, 25)];
               issue(o, rnd(), rnd(), rnd(), rnd(), 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 31)), 1'b1, w);
               repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      t = 0;
      while (sb.size() != 0 && t < BUDGET) begin
         @(negedge clk);
         t++;
      end
      check("random_drain", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/execute_pipe.md
EXECUTE_PIPE -- requirements
Module: execute_pipe

Interface
REQ-001 SHALL take parameter XLEN, default 32, datapath width; legal values are 32 and 64.
REQ-002 SHALL take parameter SHW, default $clog2(XLEN), shift-amount width.
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  in  1  the upstream instruction is valid.
REQ-006 SHALL have port in_ready  out  1  the block accepts an instruction this cycle.
REQ-007 SHALL have port flush  in  1  kill the in-flight and output-slot instruction.
REQ-008 SHALL have port op  in  5  operation code, per REQ-017.
REQ-009 SHALL have port use_imm  in  1  operand B = imm when 1, else rs2_value.
REQ-010 SHALL have ports rs1_value, rs2_value, imm, PC  in  XLEN each  operands.
REQ-011 SHALL have port in_RegDest  in  5  destination register.
REQ-012 SHALL have port out_valid  out  1  the output slot holds a result.
REQ-013 SHALL have port out_ready  in  1  downstream consumes the slot.
REQ-014 SHALL have port result  out  XLEN  operation result.
REQ-015 SHALL have port out_RegDest  out  5  registered copy of in_RegDest.
REQ-016 SHALL have ports branch_taken (1 bit) and branch_target (XLEN bits), out  resolved branch.

Function
REQ-017 Op codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 LUI (B passthrough), 11 AUIPC (PC+B), 16 BEQ, 17 BNE, 20 BLT, 21 BGE, 22 BLTU, 23 BGEU, 24 MUL, 28 DIV, 29 DIVU, 30 REM, 31 REMU; any other code behaves as ADD.
REQ-018 Handshake: an instruction is accepted when in_valid && in_ready; in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
REQ-019 Output slot: out_valid, result, out_RegDest, branch_taken and branch_target SHALL hold stable while out_valid && !out_ready; the slot clears on out_valid && out_ready unless it is refilled in the same cycle.
REQ-020 Single-cycle ops (codes 0-23): the result is loaded into the slot on the accepting edge; out_valid is 1 the following cycle (latency 1); back-to-back acceptance SHALL sustain 1 op/cycle with out_ready=1.
REQ-021 Arithmetic: all operations are modulo 2^XLEN; shifts use B[SHW-1:0]; SLT/BLT/BGE are signed; SLTU/BLTU/BGEU are unsigned.
REQ-022 Branch ops: result = PC+4; branch_target = PC+imm (always imm, regardless of use_imm); branch_taken = compare(rs1_value, rs2_value); branch_taken SHALL be 0 for all non-branch ops.
REQ-023 FSM states: IDLE, MUL, DIV. IDLE->MUL or IDLE->DIV on accepting codes 24 or 28-31; MUL/DIV->IDLE after XLEN iteration cycles, loading the slot on that edge; latency from accept to out_valid SHALL be XLEN+1 cycles.
REQ-024 MUL: shift-add over XLEN cycles; result = low XLEN bits of the product.
REQ-025 DIV: restoring division over XLEN cycles on absolute values for signed ops; sign correction is applied on the final edge.
REQ-026 Divide by zero: quotient = all ones; remainder = dividend.
REQ-027 Signed overflow (MIN / -1): quotient = MIN; remainder = 0.
REQ-028 Iteration counter: width SHW+1 bits; counts 0..XLEN-1 with no wrap.
REQ-029 Flush: on an edge with flush=1, out_valid <= 0 and state <= IDLE, aborting any MUL/DIV; in_ready is 0 during that cycle, so no instruction is accepted.
REQ-030 A completing MUL/DIV while the slot is occupied and out_ready=0 SHALL remain in its final state until the slot frees, then load it.

Reset
REQ-031 While rst is high: state = IDLE, counter = 0, out_valid = 0, result = 0, out_RegDest = 0, branch_taken = 0, branch_target = 0; in_ready SHALL be 0 while rst is asserted.
REQ-032 Reset asserted mid-MUL/DIV SHALL discard the operation; no out_valid is produced afterwards.

Verification
REQ-033 ADD rs1=5, rs2=7, use_imm=0 accepted at cycle N -> out_valid at N+1, result=12; SUB 0-1 -> result 0xFFFFFFFF.
REQ-034 BLT rs1=-1, rs2=1, PC=0x100, imm=0x20 -> branch_taken=1, target=0x120, result=0x104; BLTU with the same operands -> taken=0.
REQ-035 DIV 7 / 0 -> 0xFFFFFFFF; REM 7 % 0 -> 7; DIV 0x80000000 / -1 -> 0x80000000; DIV -7 / 2 -> -3; latency 33 cycles (XLEN=32).
REQ-036 MUL accepted, out_ready held 0 for 5 cycles after completion -> outputs stable, in_ready=0; release -> one transfer, then in_ready=1.
REQ-037 Flush asserted at iteration 10 of DIVU -> no out_valid; the next ADD is accepted the following cycle and completes normally.
REQ-038 XLEN=64 rerun of REQ-033 through REQ-035 with 64-bit extremes; MUL latency 65 cycles.
